// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock minutes/hours stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package relogio_pkg;

  // User mode: normal counting, setting hours, setting minutes.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } modo_t;

  // Largest minutes-tens digit and largest BCD digit.
  localparam int MIN_MAX_MSD = 5;
  localparam int BCD_MAX     = 9;

endpackage

// File: rtl/contador_bcd.sv
// Two-digit BCD counter, modulo MODULO, advancing by one on each inc.
// Latency: digits show the new value on the edge that samples inc.
// Backpressure: none; every inc is consumed on the cycle it is seen.
module contador_bcd
  import relogio_pkg::*;
#(
  parameter int MODULO = 60,
  parameter int MSD_W  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [3:0]       lsd,
  output logic [MSD_W-1:0] msd,
  output logic             wrap
);

  localparam int MAX_MSD = (MODULO - 1) / 10;
  localparam int MAX_LSD = (MODULO - 1) % 10;

  logic no_max;

  // Counter sits on its last value (e.g. 59 or 23).
  assign no_max = (msd == MSD_W'(MAX_MSD)) && (lsd == 4'(MAX_LSD));

  // This inc rolls the counter back to 00; feeds carries and day pulse.
  assign wrap = inc && no_max;

  // Digit update: wrap to 00, carry units into tens, or bump units.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lsd <= '0;
      msd <= '0;
    end else if (inc) begin
      if (no_max) begin
        lsd <= '0;
        msd <= '0;
      end else if (lsd == 4'(BCD_MAX)) begin
        lsd <= '0;
        msd <= msd + MSD_W'(1);
      end else begin
        lsd <= lsd + 4'd1;
      end
    end
  end

endmodule

// File: rtl/maq_mh.sv
// Minutes/hours stage: BCD time keeping, time-setting FSM, day and seconds-reset pulses.
// Latency: one cycle from any input pulse to the registered outputs.
// Backpressure: none; pulses are consumed on the cycle they arrive, ignored ones are lost.
module maq_mh
  import relogio_pkg::*;
#(
  parameter int HORAS_DIA = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       incrementa_minuto,
  input  logic       btn_modo,
  input  logic       btn_ajuste,
  output logic [3:0] bcd_m_lsd,
  output logic [2:0] bcd_m_msd,
  output logic [3:0] bcd_h_lsd,
  output logic [1:0] bcd_h_msd,
  output logic       ajustando_h,
  output logic       ajustando_m,
  output logic       zera_segundos,
  output logic       incrementa_dia
);

  modo_t estado;
  modo_t prox;
  logic  rodando;
  logic  inc_min;
  logic  inc_hora;
  logic  min_wrap;
  logic  hora_wrap;

  // Mode sequence RUN -> SET_H -> SET_M -> RUN on each btn_modo.
  always_comb begin
    prox = estado;
    if (btn_modo) begin
      case (estado)
        RUN:     prox = SET_H;
        SET_H:   prox = SET_M;
        default: prox = RUN;
      endcase
    end
  end

  // Increment steering: the clock ticks only in RUN; in setting modes the
  // adjust button drives a single field, and a mode press drops it.
  always_comb begin
    rodando  = (estado == RUN);
    inc_min  = (rodando && incrementa_minuto) ||
               ((estado == SET_M) && btn_ajuste && !btn_modo);
    inc_hora = (rodando && min_wrap) ||
               ((estado == SET_H) && btn_ajuste && !btn_modo);
  end

  contador_bcd #(
    .MODULO ((MIN_MAX_MSD + 1) * 10),
    .MSD_W  (3)
  ) u_minutos (
    .clock (clock),
    .reset (reset),
    .inc   (inc_min),
    .lsd   (bcd_m_lsd),
    .msd   (bcd_m_msd),
    .wrap  (min_wrap)
  );

  contador_bcd #(
    .MODULO (HORAS_DIA),
    .MSD_W  (2)
  ) u_horas (
    .clock (clock),
    .reset (reset),
    .inc   (inc_hora),
    .lsd   (bcd_h_lsd),
    .msd   (bcd_h_msd),
    .wrap  (hora_wrap)
  );

  // State register plus registered mode flags and one-cycle output pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= RUN;
      ajustando_h    <= 1'b0;
      ajustando_m    <= 1'b0;
      zera_segundos  <= 1'b0;
      incrementa_dia <= 1'b0;
    end else begin
      estado         <= prox;
      ajustando_h    <= (prox == SET_H);
      ajustando_m    <= (prox == SET_M);
      zera_segundos  <= (estado == SET_M) && btn_modo;
      incrementa_dia <= rodando && hora_wrap;
    end
  end

endmodule

// File: tb/tb_maq_mh.sv
module tb_maq_mh;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic incrementa_minuto = 1'b0;
  logic btn_modo = 1'b0;
  logic btn_ajuste = 1'b0;

  logic [3:0] m_lsd [2];
  logic [2:0] m_msd [2];
  logic [3:0] h_lsd [2];
  logic [1:0] h_msd [2];
  logic       aj_h  [2];
  logic       aj_m  [2];
  logic       zera  [2];
  logic       dia   [2];

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 is the 24-hour DUT, index 1 the 12-hour DUT.
  int mdl_min  [2];
  int mdl_hora [2];
  int mdl_modo [2];   // 0 running, 1 setting hours, 2 setting minutes
  int mdl_zera [2];
  int mdl_dia  [2];
  int horas    [2] = '{24, 12};

  always #5 clock = ~clock;

  maq_mh #(.HORAS_DIA(24)) dut24 (
    .clock(clock), .reset(reset), .incrementa_minuto(incrementa_minuto),
    .btn_modo(btn_modo), .btn_ajuste(btn_ajuste),
    .bcd_m_lsd(m_lsd[0]), .bcd_m_msd(m_msd[0]), .bcd_h_lsd(h_lsd[0]), .bcd_h_msd(h_msd[0]),
    .ajustando_h(aj_h[0]), .ajustando_m(aj_m[0]),
    .zera_segundos(zera[0]), .incrementa_dia(dia[0])
  );

  maq_mh #(.HORAS_DIA(12)) dut12 (
    .clock(clock), .reset(reset), .incrementa_minuto(incrementa_minuto),
    .btn_modo(btn_modo), .btn_ajuste(btn_ajuste),
    .bcd_m_lsd(m_lsd[1]), .bcd_m_msd(m_msd[1]), .bcd_h_lsd(h_lsd[1]), .bcd_h_msd(h_msd[1]),
    .ajustando_h(aj_h[1]), .ajustando_m(aj_m[1]),
    .zera_segundos(zera[1]), .incrementa_dia(dia[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, (k == 0) ? " h24 min" : " h12 min"}, {1'b0, m_msd[k], m_lsd[k]},
          8'(((mdl_min[k] / 10) << 4) | (mdl_min[k] % 10)));
      chk({tag, (k == 0) ? " h24 hour" : " h12 hour"}, {2'b0, h_msd[k], h_lsd[k]},
          8'(((mdl_hora[k] / 10) << 4) | (mdl_hora[k] % 10)));
      chk({tag, (k == 0) ? " h24 flags" : " h12 flags"},
          {4'b0, aj_h[k], aj_m[k], zera[k], dia[k]},
          8'({(mdl_modo[k] == 1), (mdl_modo[k] == 2), (mdl_zera[k] != 0), (mdl_dia[k] != 0)}));
    end
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      mdl_min[k] = 0; mdl_hora[k] = 0; mdl_modo[k] = 0; mdl_zera[k] = 0; mdl_dia[k] = 0;
    end
  endtask

  task automatic mdl_step(input logic mi, input logic mo, input logic aj);
    for (int k = 0; k < 2; k++) begin
      mdl_zera[k] = 0;
      mdl_dia[k]  = 0;
      case (mdl_modo[k])
        0: begin
          if (mi) begin
            mdl_min[k]++;
            if (mdl_min[k] == 60) begin
              mdl_min[k] = 0;
              mdl_hora[k]++;
              if (mdl_hora[k] == horas[k]) begin
                mdl_hora[k] = 0;
                mdl_dia[k] = 1;
              end
            end
          end
          if (mo) mdl_modo[k] = 1;
        end
        1: begin
          if (mo) mdl_modo[k] = 2;
          else if (aj) mdl_hora[k] = (mdl_hora[k] + 1) % horas[k];
        end
        default: begin
          if (mo) begin
            mdl_modo[k] = 0;
            mdl_zera[k] = 1;
          end else if (aj) mdl_min[k] = (mdl_min[k] + 1) % 60;
        end
      endcase
    end
  endtask

  // One clock cycle with the given input pulses, then model update and full check.
  task automatic step(input string tag, input logic mi, input logic mo, input logic aj);
    incrementa_minuto = mi;
    btn_modo = mo;
    btn_ajuste = aj;
    @(posedge clock);
    #1;
    incrementa_minuto = 1'b0;
    btn_modo = 1'b0;
    btn_ajuste = 1'b0;
    mdl_step(mi, mo, aj);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    mdl_reset();
    check_all({tag, " async"});
    @(posedge clock);
    #1;
    check_all({tag, " held"});
    reset = 1'b0;
  endtask

  // From RUN, set the 24-hour DUT to hh:mm via the buttons and return to RUN.
  task automatic set_time(input string tag, input int hh, input int mm);
    int n;
    step({tag, " modo1"}, 1'b0, 1'b1, 1'b0);
    n = (hh - mdl_hora[0] + 24) % 24;
    for (int i = 0; i < n; i++) step({tag, " aj_h"}, 1'b0, 1'b0, 1'b1);
    step({tag, " modo2"}, 1'b0, 1'b1, 1'b0);
    n = (mm - mdl_min[0] + 60) % 60;
    for (int i = 0; i < n; i++) step({tag, " aj_m"}, 1'b0, 1'b0, 1'b1);
    step({tag, " modo3"}, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    mdl_reset();
    #2;
    do_reset("por");

    // Count up at 13:47 then reset asynchronously between edges.
    set_time("to1347", 13, 47);
    chk("at 13:47", {h_msd[0], h_lsd[0], m_msd[0][0], m_lsd[0]}, {2'd1, 4'd3, 1'b0, 4'd7});
    step("run1", 1'b1, 1'b0, 1'b0);
    step("run2", 1'b1, 1'b0, 1'b0);
    #3;
    do_reset("midreset");

    // Hour wrap at 24 during setting, minute wrap at 60, seconds-reset pulse.
    step("set modo", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step("aj25", 1'b0, 1'b0, 1'b1);
    chk("hours after 25 presses", {h_msd[0], h_lsd[0]}, 6'd1);
    step("set modo2", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 61; i++) step("aj61", 1'b0, 1'b0, 1'b1);
    chk("minutes after 61 presses", {m_msd[0], m_lsd[0]}, 7'd1);
    for (int i = 0; i < 5; i++) step("frozen SET_M", 1'b1, 1'b0, 1'b0);
    step("exit SET_M", 1'b0, 1'b1, 1'b0);
    chk("zera pulse", {7'd0, zera[0]}, 8'd1);
    step("zera drops", 1'b0, 1'b0, 1'b0);
    step("ajuste in RUN", 1'b0, 1'b0, 1'b1);

    // 12:59 -> 13:00 without day carry.
    set_time("to1259", 12, 59);
    step("1259 inc", 1'b1, 1'b0, 1'b0);
    chk("13:00 no dia", {dia[0], h_msd[0], h_lsd[0], m_msd[0], m_lsd[0]}, {1'b0, 2'd1, 4'd3, 3'd0, 4'd0});

    // 23:59 -> 00:00 with a one-cycle day pulse.
    set_time("to2359", 23, 59);
    step("2359 inc", 1'b1, 1'b0, 1'b0);
    chk("dia at 00:00", {7'd0, dia[0]}, 8'd1);
    step("dia drops", 1'b1, 1'b0, 1'b0);

    // Simultaneous events.
    set_time("to1009", 10, 9);
    step("modo+inc", 1'b1, 1'b1, 1'b0);
    chk("10:10 in SET_H", {aj_h[0], m_msd[0], m_lsd[0]}, {1'b1, 3'd1, 4'd0});
    step("modo+aj", 1'b0, 1'b1, 1'b1);
    chk("SET_M hours kept", {aj_m[0], h_msd[0], h_lsd[0]}, {1'b1, 2'd1, 4'd0});
    step("back run", 1'b0, 1'b1, 1'b0);

    // 12-hour instance: 11:59 -> 00:00 with day pulse.
    do_reset("pre12");
    set_time("to1159", 11, 59);
    step("1159 inc", 1'b1, 1'b0, 1'b0);
    chk("h12 dia", {dia[1], h_msd[1], h_lsd[1], m_msd[1], m_lsd[1]}, {1'b1, 2'd0, 4'd0, 3'd0, 4'd0});

    // Random traffic, mostly counting with occasional mode/adjust presses.
    for (int i = 0; i < 4000; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maq_mh.md
# maq_mh

Minutes-and-hours stage of the clock, directly downstream of the seconds counter. Consumes the seconds stage's one-cycle `incrementa_minuto` pulse, keeps minutes (00–59) and hours (00–23 by default) in BCD, and emits a day-carry pulse. Includes a user time-setting state machine driven by two debounced buttons. On exit from setting mode it requests a seconds reset so the set time starts cleanly at :00.

## Interface
- `HORAS_DIA`, default 24: hour modulus. Legal values are 24 (hours 00–23) and 12 (hours 00–11).
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset. Clears all state.
- `incrementa_minuto`  in  1: one-cycle pulse from the seconds stage.
- `btn_modo`  in  1: one-cycle pulse, already synchronised and debounced. Advances the mode.
- `btn_ajuste`  in  1: one-cycle pulse, already synchronised and debounced. Increments the field being set.
- `bcd_m_lsd`  out  4: minutes units, 0–9.
- `bcd_m_msd`  out  3: minutes tens, 0–5.
- `bcd_h_lsd`  out  4: hours units.
- `bcd_h_msd`  out  2: hours tens.
- `ajustando_h`  out  1: high while in SET_H.
- `ajustando_m`  out  1: high while in SET_M.
- `zera_segundos`  out  1: one-cycle pulse on SET_M→RUN.
- `incrementa_dia`  out  1: one-cycle pulse on the running wrap from last hour:59 to 00:00.

## Operation
- Reset: all BCD digits 0, state RUN, all flags and pulses 0. Reset applies immediately and asynchronously, including mid-setting.
- State machine:
  - Three states: RUN, SET_H, SET_M.
  - `btn_modo` advances RUN→SET_H→SET_M→RUN.
  - There are no other transitions.
- RUN, on `incrementa_minuto`:
  - Minutes units +1; units 9 → 0 with tens +1.
  - At 59, minutes → 00 and hours +1 in BCD.
  - At the last hour (23, or 11 when `HORAS_DIA`=12) with minutes 59, time → 00:00 and `incrementa_dia` pulses.
- SET_H, on `btn_ajuste`:
  - Hours +1 modulo `HORAS_DIA`; last hour → 00.
  - No `incrementa_dia`; minutes untouched.
- SET_M, on `btn_ajuste`:
  - Minutes +1 modulo 60; 59 → 00.
  - No carry into hours; no `incrementa_dia`.
- In SET_H and SET_M, `incrementa_minuto` is ignored and the time stays frozen. Minutes elapsed during setting are intentionally lost.
- `btn_ajuste` in RUN is ignored.
- Simultaneous events:
  - `btn_modo` with `incrementa_minuto` in RUN: the increment is applied and the state moves to SET_H, both in the same edge.
  - `btn_modo` with `btn_ajuste` in SET_H or SET_M: the mode change wins and `btn_ajuste` is dropped.
- BCD digits never take illegal values: minutes tens ≤ 5, units ≤ 9, hours ≤ `HORAS_DIA`−1.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Counter update latency: the digits show the new value on the rising edge that samples the pulse, i.e. one cycle after the pulse is driven.
- `incrementa_dia` is high for exactly the one cycle in which the digits first show 00:00.
- `zera_segundos` is high for exactly the one cycle after the `btn_modo` edge that leaves SET_M.
- `ajustando_h` and `ajustando_m` are decoded from the state register, registered. They change on the same edge as the state.
- Back-to-back `incrementa_minuto` pulses on consecutive cycles must each count; there is no dead cycle.

## Structure
- Shared package `relogio_pkg` holds:
  - state enum `modo_t` {RUN, SET_H, SET_M};
  - constants `MIN_MAX_MSD`=5 and `BCD_MAX`=9.
- Natural sub-module: `contador_bcd`, a two-digit BCD counter with a modulus parameter, `inc` input, and `wrap` output. It is instantiated once for minutes (mod 60) and once for hours (mod `HORAS_DIA`).
- The top-level holds the FSM, the increment steering (run vs. set), and the output pulse registers.

## Test plan
- Reset mid-count at 13:47: assert `reset` asynchronously → all digits 0, state RUN, `zera_segundos`=0 and `incrementa_dia`=0 before the next edge.
- Preload 12:59 via the set modes, return to RUN, one `incrementa_minuto` → 13:00, `incrementa_dia`=0.
- From 23:59 in RUN, one `incrementa_minuto` → 00:00, `incrementa_dia` high for exactly one cycle.
- Setting sequence:
  - `btn_modo`, then 25 `btn_ajuste` → hours 01 (wrap at 24);
  - `btn_modo`, then 61 `btn_ajuste` → minutes 01, hours still 01;
  - `btn_modo` → RUN, `zera_segundos` one-cycle pulse.
- In SET_M, drive `incrementa_minuto` on 5 consecutive cycles → time unchanged.
- Simultaneous events:
  - RUN at 10:09, `btn_modo` and `incrementa_minuto` on the same cycle → 10:10 and `ajustando_h`=1 on the same edge;
  - in SET_H, `btn_modo` and `btn_ajuste` on the same cycle → hours unchanged, state SET_M.
- `HORAS_DIA`=12: from 11:59, one `incrementa_minuto` → 00:00 with an `incrementa_dia` pulse.
